// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - circular return-address predictor, push-on-full wraps when RAS_OVERFLOW_WRAP_EN is defined
module return_address_stack #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_is_ret,
    input  logic                     exe_valid,
    input  logic [6:0]               exe_opcode,
    input  logic [4:0]               exe_rd,
    input  logic [4:0]               exe_rs1,
    input  logic [31:0]              exe_pc,
    input  logic                     flush,
    output logic [31:0]              ret_PC,
    output logic                     ret_hit,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic [PW-1:0] tp_q, tp_d, tp_inc;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   entry_q [DEPTH];

    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic [31:0]   wr_val;

    logic rd_link, rs1_link, is_jal, is_jalr;
    logic do_push, do_pop, do_swap;
    logic empty_w, full_w;

    assign rd_link  = (exe_rd == 5'd1) || (exe_rd == 5'd5);
    assign rs1_link = (exe_rs1 == 5'd1) || (exe_rs1 == 5'd5);
    assign is_jal   = (exe_opcode == OP_JAL);
    assign is_jalr  = (exe_opcode == OP_JALR);

    assign do_push = exe_valid && ((is_jal && rd_link) ||
                     (is_jalr && rd_link && (!rs1_link || (exe_rd == exe_rs1))));
    assign do_pop  = exe_valid && is_jalr && !rd_link && rs1_link;
    assign do_swap = exe_valid && is_jalr && rd_link && rs1_link && (exe_rd != exe_rs1);

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));
    assign tp_inc  = tp_q + PW'(1);

    always_comb begin
        tp_d    = tp_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = tp_q;
        wr_val  = exe_pc + 32'd4;
        if (flush) begin
            tp_d    = '0;
            count_d = '0;
        end else if (do_pop) begin
            if (!empty_w) begin
                tp_d    = tp_q - PW'(1);
                count_d = count_q - CW'(1);
            end
        end else if (do_swap && !empty_w) begin
            // coroutine swap: replace the top in place
            wr_en = 1'b1;
        end else if (do_push || do_swap) begin
            if (!full_w) begin
                wr_en   = 1'b1;
                wr_idx  = tp_inc;
                tp_d    = tp_inc;
                count_d = count_q + CW'(1);
            end
`ifdef RAS_OVERFLOW_WRAP_EN
            else begin
                // slot tp+1 holds the oldest entry once full
                wr_en  = 1'b1;
                wr_idx = tp_inc;
                tp_d   = tp_inc;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
            if (wr_en) begin
                entry_q[wr_idx] <= wr_val;
            end
        end
    end

    assign empty   = empty_w;
    assign full    = full_w;
    assign count   = count_q;
    assign ret_hit = fetch_is_ret && !empty_w;
    assign ret_PC  = ret_hit ? entry_q[tp_q] : 32'd0;

endmodule

// File: tb/tb_return_address_stack.sv
// tb/tb_return_address_stack.sv - directed bench for return_address_stack (DEPTH=8)
module tb_return_address_stack;

    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ADDI = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_is_ret;
    logic        exe_valid;
    logic [6:0]  exe_opcode;
    logic [4:0]  exe_rd;
    logic [4:0]  exe_rs1;
    logic [31:0] exe_pc;
    logic        flush;
    logic [31:0] ret_PC;
    logic        ret_hit;
    logic        empty;
    logic        full;
    logic [3:0]  count;

    int vectors = 0;
    int miscompares = 0;

    return_address_stack #(.DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_is_ret(fetch_is_ret),
        .exe_valid(exe_valid), .exe_opcode(exe_opcode), .exe_rd(exe_rd),
        .exe_rs1(exe_rs1), .exe_pc(exe_pc), .flush(flush),
        .ret_PC(ret_PC), .ret_hit(ret_hit), .empty(empty), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic exe(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [31:0] pc);
        exe_valid = v; exe_opcode = op; exe_rd = rd; exe_rs1 = rs1; exe_pc = pc;
        @(posedge clk); #1;
        exe_valid = 1'b0; exe_opcode = ADDI; exe_rd = 5'd0; exe_rs1 = 5'd0; exe_pc = 32'd0;
    endtask

    task automatic call(input logic [31:0] pc);
        exe(1'b1, JAL, 5'd1, 5'd0, pc);
    endtask

    task automatic ret();
        exe(1'b1, JALR, 5'd0, 5'd1, 32'h0);
    endtask

    task automatic peek(input string tag, input logic hit, input logic [31:0] pc);
        fetch_is_ret = 1'b1; #1;
        chk({tag, "_hit"}, {31'd0, ret_hit}, {31'd0, hit});
        chk({tag, "_pc"}, ret_PC, pc);
        fetch_is_ret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_is_ret = 1'b0; flush = 1'b0;
        exe_valid = 1'b0; exe_opcode = ADDI; exe_rd = 0; exe_rs1 = 0; exe_pc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        peek("rst", 1'b0, 32'd0);
        rst_n = 1'b1;

        // call then return
        call(32'h100);
        peek("call1", 1'b1, 32'h104);
        chk("call1_count", {28'd0, count}, 32'd1);
        fetch_is_ret = 1'b1;
        ret();
        chk("ret1_empty", {31'd0, empty}, 32'd1);
        peek("ret1", 1'b0, 32'd0);

        // nesting
        call(32'h100); call(32'h200); call(32'h300);
        peek("nest0", 1'b1, 32'h304); ret();
        peek("nest1", 1'b1, 32'h204); ret();
        peek("nest2", 1'b1, 32'h104); ret();
        peek("nest3", 1'b0, 32'd0);

        // overflow: 10 pushes
        for (int i = 0; i < 10; i++) call(32'h1000 + 32'(16 * i));
        chk("ovf_count", {28'd0, count}, 32'd8);
        chk("ovf_full", {31'd0, full}, 32'd1);
        for (int j = 0; j < 8; j++) begin
`ifdef RAS_OVERFLOW_WRAP_EN
            peek($sformatf("ovf_pop%0d", j), 1'b1, 32'h1094 - 32'(16 * j));
`else
            peek($sformatf("ovf_pop%0d", j), 1'b1, 32'h1074 - 32'(16 * j));
`endif
            ret();
        end
        chk("ovf_drained", {31'd0, empty}, 32'd1);

        // coroutine swap
        call(32'h100);
        exe(1'b1, JALR, 5'd1, 5'd5, 32'h400);
        peek("swap_ne", 1'b1, 32'h404);
        chk("swap_ne_count", {28'd0, count}, 32'd1);
        ret();
        exe(1'b1, JALR, 5'd1, 5'd5, 32'h400);
        peek("swap_e", 1'b1, 32'h404);
        chk("swap_e_count", {28'd0, count}, 32'd1);
        exe(1'b1, JALR, 5'd1, 5'd1, 32'h500);
        peek("samelink", 1'b1, 32'h504);
        chk("samelink_count", {28'd0, count}, 32'd2);
        exe(1'b1, JALR, 5'd5, 5'd5, 32'h600);
        chk("samelink5_count", {28'd0, count}, 32'd3);

        // flush, underflow, gating
        flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
        chk("flush_count", {28'd0, count}, 32'd0);
        ret();
        chk("underflow_count", {28'd0, count}, 32'd0);
        call(32'h700);
        flush = 1'b1; call(32'h800); flush = 1'b0;
        chk("flush_push_count", {28'd0, count}, 32'd0);
        call(32'h900);
        exe(1'b0, JAL, 5'd1, 5'd0, 32'hA00);
        chk("gated_count", {28'd0, count}, 32'd1);
        peek("gated", 1'b1, 32'h904);
        exe(1'b1, ADDI, 5'd1, 5'd1, 32'hB00);
        chk("nonjump_count", {28'd0, count}, 32'd1);
        exe(1'b1, JAL, 5'd2, 5'd0, 32'hC00);
        chk("jal_nolink_count", {28'd0, count}, 32'd1);

        // mid-run reset
        for (int i = 0; i < 4; i++) call(32'h2000 + 32'(16 * i));
        chk("pre_rst_count", {28'd0, count}, 32'd5);
        rst_n = 1'b0; call(32'h3000); rst_n = 1'b1;
        chk("midrst_count", {28'd0, count}, 32'd0);
        peek("midrst", 1'b0, 32'd0);
        call(32'h4000);
        peek("post_rst", 1'b1, 32'h4004);
        ret();
        peek("post_rst_pop", 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
